// File: rtl/cpu_types_pkg.sv
// Shared core types for the pipelined MIPS core.
//   word_t        : 32-bit machine word (instructions, addresses, data).
//   opcode_t      : 6-bit primary opcode field, instr[31:26].
//   fetch_state_t : fetch-stage state (RUN, HALTED).
//   PC_STEP       : sequential PC increment in bytes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and the icache/arbiter.
//   imemREN  : read request (fetch -> cache)
//   imemaddr : instruction address (fetch -> cache)
//   ihit     : imemload valid this cycle (cache -> fetch)
//   imemload : instruction word (cache -> fetch)
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport master (
        output imemREN,
        output imemaddr,
        input  ihit,
        input  imemload
    );

    modport slave (
        input  imemREN,
        input  imemaddr,
        output ihit,
        output imemload
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: instruction word, its PC+4 and a valid bit.
// Per-cycle priority: clear_i (valid <= 0, payload holds) > hold_i (all hold)
// > load_i (capture payload, valid <= 1) > otherwise bubble (valid <= 0).
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset (all fields to 0)
//   clear_i, hold_i    : bubble insert / freeze controls
//   load_i             : capture instr_i / npc_i
//   instr_o, npc_o     : latched instruction and PC+4
//   valid_o            : latch holds a real instruction
module if_id_reg
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clear_i,
    input  logic  hold_i,
    input  logic  load_i,
    input  word_t instr_i,
    input  word_t npc_i,
    output word_t instr_o,
    output word_t npc_o,
    output logic  valid_o
);

    word_t instr_q, instr_d;
    word_t npc_q, npc_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (hold_i) begin
            valid_d = valid_q;
        end else if (load_i) begin
            instr_d = instr_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID latch of the pipelined MIPS core.
// Owns the PC, issues reads on the imem bus, latches returned words into
// IF/ID and exposes op/func to the decode control unit.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   imem                : icache request bus (master side)
//   stall, flush        : hazard-unit hold / bubble requests
//   redirect_en/_pc     : resolved branch/jump target
//   halt                : decoded halt on a valid ID instruction
//   instr_out, npc_out  : IF/ID instruction and its PC+4
//   valid_out           : IF/ID holds a real instruction
//   op_out, func_out    : instr_out[31:26] / instr_out[5:0]
//   halted              : fetch stopped until reset
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned         WORD_W  = 32,
    parameter logic [WORD_W-1:0]   PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output word_t             instr_out,
    output word_t             npc_out,
    output logic              valid_out,
    output opcode_t           op_out,
    output logic [5:0]        func_out,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc_plus4;
    logic              latch_clear;
    logic              latch_hold;
    logic              latch_load;

    // Modulo WORD_W: the top word wraps to address 0.
    assign pc_plus4 = pc_q + WORD_W'(PC_STEP);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        latch_clear = 1'b0;
        latch_hold  = 1'b0;
        latch_load  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_en) begin
                    // Redirecting instruction is older; any halt is wrong-path.
                    pc_d        = redirect_pc;
                    latch_clear = 1'b1;
                end else if (halt) begin
                    state_d     = HALTED;
                    latch_clear = 1'b1;
                end else if (flush && !stall) begin
                    latch_clear = 1'b1;
                    if (imem.ihit) begin
                        pc_d = pc_plus4;
                    end
                end else if (stall) begin
                    // ihit ignored; the same address is re-read after the stall.
                    latch_hold = 1'b1;
                end else if (imem.ihit) begin
                    latch_load = 1'b1;
                    pc_d       = pc_plus4;
                end else begin
                    latch_clear = 1'b1;
                end
            end
            HALTED: begin
                latch_clear = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (latch_clear),
        .hold_i  (latch_hold),
        .load_i  (latch_load),
        .instr_i (imem.imemload),
        .npc_i   (pc_plus4),
        .instr_o (instr_out),
        .npc_o   (npc_out),
        .valid_o (valid_out)
    );

    assign imem.imemREN  = (state_q == RUN);
    assign imem.imemaddr = pc_q;
    assign halted        = (state_q == HALTED);
    assign op_out        = opcode_t'(instr_out[31:26]);
    assign func_out      = instr_out[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Stimulus pushes each expected IF/ID
// (instr, npc) pair into a queue; a monitor pops and compares whenever a new
// valid IF/ID entry appears. Control outputs are checked directly.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        stall, flush, redirect_en, halt;
    word_t       redirect_pc;
    word_t       instr_out, npc_out;
    logic        valid_out, halted;
    opcode_t     op_out;
    logic [5:0]  func_out;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .WORD_W  (32),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem        (imem_bus.master),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_out   (instr_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out),
        .op_out      (op_out),
        .func_out    (func_out),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        word_t instr;
        word_t npc;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  prev_v = 1'b0;
    word_t prev_i = '0;
    word_t prev_n = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_latch(input word_t instr, input word_t npc);
        exp_t e;
        e.instr = instr;
        e.npc   = npc;
        exp_q.push_back(e);
    endtask

    // Monitor: a new IF/ID entry is a valid entry differing from the last sample.
    always @(negedge CLK) begin
        exp_t e;
        if (valid_out && (!prev_v || instr_out != prev_i || npc_out != prev_n)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_latch: got instr %h npc %h, expected none",
                         instr_out, npc_out);
            end else begin
                e = exp_q.pop_front();
                check("latch_instr", instr_out, e.instr);
                check("latch_npc", npc_out, e.npc);
            end
        end
        prev_v = valid_out;
        prev_i = instr_out;
        prev_n = npc_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        stall = 0; flush = 0; redirect_en = 0; halt = 0; redirect_pc = '0;
        imem_bus.ihit = 0; imem_bus.imemload = '0;
        tick(); tick();
        check("rst_addr", imem_bus.imemaddr, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_npc", npc_out, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_ren", {31'b0, imem_bus.imemREN}, 32'd1);

        // Back-to-back hits.
        RST = 1'b0;
        imem_bus.ihit = 1; imem_bus.imemload = 32'h8C01_0004;
        expect_latch(32'h8C01_0004, 32'h4);
        tick();
        check("seq_addr4", imem_bus.imemaddr, 32'h4);
        check("seq_op", {26'b0, op_out}, 32'h23);
        imem_bus.imemload = 32'h0022_1820;
        expect_latch(32'h0022_1820, 32'h8);
        tick();
        check("seq_addr8", imem_bus.imemaddr, 32'h8);
        check("seq_func", {26'b0, func_out}, 32'h20);

        // Cache miss for three cycles at PC=8.
        imem_bus.ihit = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("miss_addr", imem_bus.imemaddr, 32'h8);
            check("miss_valid", {31'b0, valid_out}, 32'd0);
        end
        imem_bus.ihit = 1; imem_bus.imemload = 32'h2002_000A;
        expect_latch(32'h2002_000A, 32'hC);
        tick();
        check("miss_hit_addr", imem_bus.imemaddr, 32'hC);
        imem_bus.imemload = 32'h2003_0005;
        expect_latch(32'h2003_0005, 32'h10);
        tick();

        // Stall with ihit high at PC=0x10.
        stall = 1; imem_bus.imemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_addr", imem_bus.imemaddr, 32'h10);
            check("stall_instr", instr_out, 32'h2003_0005);
            check("stall_valid", {31'b0, valid_out}, 32'd1);
        end
        stall = 0; imem_bus.imemload = 32'h0000_0020;
        expect_latch(32'h0000_0020, 32'h14);
        tick();
        check("unstall_addr", imem_bus.imemaddr, 32'h14);

        // Redirect beats stall and halt.
        redirect_en = 1; redirect_pc = 32'h40; stall = 1; halt = 1;
        tick();
        redirect_en = 0; stall = 0; halt = 0;
        check("redir_addr", imem_bus.imemaddr, 32'h40);
        check("redir_valid", {31'b0, valid_out}, 32'd0);
        check("redir_halted", {31'b0, halted}, 32'd0);
        check("redir_instr_hold", instr_out, 32'h0000_0020);

        // Flush with a hit: PC advances, nothing latched.
        flush = 1; imem_bus.imemload = 32'h1111_1111;
        tick();
        flush = 0;
        check("flush_addr", imem_bus.imemaddr, 32'h44);
        check("flush_valid", {31'b0, valid_out}, 32'd0);

        // Halt at PC=0x20.
        imem_bus.ihit = 0;
        redirect_en = 1; redirect_pc = 32'h20;
        tick();
        redirect_en = 0;
        check("pre_halt_addr", imem_bus.imemaddr, 32'h20);
        halt = 1;
        tick();
        halt = 0;
        check("halt_ren", {31'b0, imem_bus.imemREN}, 32'd0);
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_valid", {31'b0, valid_out}, 32'd0);
        imem_bus.ihit = 1; imem_bus.imemload = 32'h2222_2222;
        redirect_en = 1; redirect_pc = 32'h80;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halted_addr", imem_bus.imemaddr, 32'h20);
            check("halted_stays", {31'b0, halted}, 32'd1);
            check("halted_valid", {31'b0, valid_out}, 32'd0);
        end
        redirect_en = 0; imem_bus.ihit = 0;
        RST = 1;
        tick();
        RST = 0;
        check("rerst_addr", imem_bus.imemaddr, 32'h0);
        check("rerst_halted", {31'b0, halted}, 32'd0);
        check("rerst_ren", {31'b0, imem_bus.imemREN}, 32'd1);

        // Wrap-around at the top of the address space.
        redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 0;
        check("wrap_addr_top", imem_bus.imemaddr, 32'hFFFF_FFFC);
        imem_bus.ihit = 1; imem_bus.imemload = 32'h0800_0000;
        expect_latch(32'h0800_0000, 32'h0);
        tick();
        imem_bus.ihit = 0;
        check("wrap_addr", imem_bus.imemaddr, 32'h0);
        tick(); tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch of the pipelined MIPS core.
- Owns the PC and issues instruction reads to the icache/arbiter.
- Latches the returned word and presents op/func fields directly to the decode-stage control unit.
- Honours hazard-unit stall/flush, branch/jump redirects, and a decoded halt.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- WORD_W, 32, instruction/address width; fixed by the core's word type.

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- imemREN  output  1  instruction read request.
- imemaddr  output  WORD_W  instruction address; always equals PC.
- ihit  input  1  icache hit; imemload valid this cycle.
- imemload  input  WORD_W  instruction word from icache.
- stall  input  1  hazard unit: hold PC and IF/ID latch.
- flush  input  1  hazard unit: insert a bubble into IF/ID.
- redirect_en  input  1  branch taken, jump, jr, or jal resolved downstream.
- redirect_pc  input  WORD_W  redirect target.
- halt  input  1  control unit decoded halt on a valid ID instruction.
- instr_out  output  WORD_W  IF/ID instruction.
- npc_out  output  WORD_W  IF/ID PC+4 of that instruction.
- valid_out  output  1  IF/ID holds a real instruction (0 = bubble).
- op_out  output  6 (opcode_t)  instr_out[31:26]; feeds control-unit op.
- func_out  output  6  instr_out[5:0]; feeds control-unit func.
- halted  output  1  fetch stopped permanently.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - PC = PC_INIT.
  - State = RUN.
  - instr_out = 0, npc_out = 0, valid_out = 0, halted = 0.
- State machine states: RUN and HALTED.
  - RUN to HALTED when halt=1 and redirect_en=0.
  - HALTED has no exit except RST.
- Outputs by state:
  - imemREN = 1 in RUN, 0 in HALTED.
  - imemaddr = PC, combinational.
  - halted = 1 iff state is HALTED.
- op_out and func_out are combinational slices of instr_out.
- Per-cycle priority in RUN, highest first:
  1. redirect_en: PC <= redirect_pc; IF/ID valid <= 0; instr_out and npc_out hold. Applies regardless of stall, ihit, flush, or halt. A redirect beats halt because the redirecting instruction is older and the halt is wrong-path.
  2. halt: state <= HALTED; IF/ID valid <= 0; PC holds.
  3. flush (no stall): IF/ID valid <= 0. PC advances only if ihit (PC <= PC+4).
  4. stall: PC, instr_out, npc_out and valid_out all hold. imemREN stays 1 and ihit is ignored; the same address re-reads after the stall.
  5. ihit: instr_out <= imemload; npc_out <= PC+4; valid_out <= 1; PC <= PC+4.
  6. No ihit: PC holds; valid_out <= 0 (bubble while waiting on the cache).
- stall and flush together: stall wins and the latch holds. The hazard unit never asserts both.
- Arithmetic: PC+4 is WORD_W-bit modulo, so 32'hFFFFFFFC wraps to 0. PC[1:0] is never checked; redirect_pc is assumed word-aligned by the producer.
- In HALTED: all inputs except RST are ignored; IF/ID valid = 0; PC frozen.
- Latency: instruction visible on instr_out the cycle after its ihit. Redirect-to-new-request latency is one cycle (imemaddr = target the next cycle).
- RST asserted mid-wait (ihit pending): the request is abandoned; imemaddr = PC_INIT the next cycle.

Decomposition:
- cpu_types_pkg:
  - Already holds word_t and opcode_t; reuse them.
  - Add fetch_state_t enum {RUN, HALTED}.
  - Add constant PC_STEP = 4.
- Sub-module if_id_reg: IF/ID latch carrying instr, npc and valid, with hold/clear inputs.
- fetch_stage keeps the PC register, the state machine and the priority logic.

Test Plan:
- Reset, then ihit=1 every cycle, instructions 0x8C010004, 0x00221820: imemaddr 0, 4, 8; instr_out 0x8C010004 with npc_out 4; op_out 6'h23; then func_out 6'h20.
- ihit low for 3 cycles at PC=8: imemaddr stays 8, valid_out=0 for 3 cycles, PC unchanged. Then hit: instr latched, npc_out=12.
- stall=1 for 2 cycles with ihit=1 at PC=0x10: PC, instr_out and valid_out hold both cycles; stall release then hit gives npc_out=0x14.
- redirect_en=1 with redirect_pc=0x40 while stall=1 and halt=1: next imemaddr=0x40, valid_out=0, halted=0.
- halt=1 alone at PC=0x20: imemREN=0 and halted=1 from the next cycle, valid_out=0. Later ihit and redirect are ignored; RST returns to PC_INIT.
- Redirect to 0xFFFFFFFC, then hit: npc_out=0 and next imemaddr=0 (wrap-around).
